// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register slice.
package usr_pkg;

  // Operation select for the register and each of its bit cells.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_SHL  = 2'b11
  } mode_t;

  // Bits needed to hold a shift count from 0 up to and including w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/usr_cell.sv
// One bit of the universal shift register: a 4:1 mode mux feeding a flop.
// "Left" is the next-higher bit (source on SHR), "right" the next-lower bit
// (source on SHL); the top module ties the end cells to the serial inputs.
module usr_cell
  import usr_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic [1:0] i_mode,
  input  logic       i_d,
  input  logic       i_from_left,
  input  logic       i_from_right,
  output logic       o_q
);

  logic r_q;
  logic w_next;

  // Pick this bit's next value from hold, parallel data or a neighbour.
  always_comb begin
    w_next = r_q;
    case (mode_t'(i_mode))
      MODE_HOLD: w_next = r_q;
      MODE_LOAD: w_next = i_d;
      MODE_SHR:  w_next = i_from_left;
      MODE_SHL:  w_next = i_from_right;
      default:   w_next = r_q;
    endcase
  end

  // Reset wins over enable; with enable low the bit simply holds.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= RESET_BIT;
    end else if (i_en) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, parallel load, shift right
// and shift left, with serial in/out at both ends and a saturating shift
// counter whose DONE flag marks a fully serialised word.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              CW          = cnt_width(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_si_msb,
  input  logic             i_si_lsb,
  output logic [WIDTH-1:0] o_q,
  output logic             o_so_lsb,
  output logic             o_so_msb,
  output logic [CW-1:0]    o_cnt,
  output logic             o_done
);

  logic [WIDTH-1:0] w_q;
  logic [CW-1:0]    r_cnt;
  logic             w_full;

  // One cell per bit; the end cells take the serial inputs as neighbours.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_left;
    logic w_right;

    if (i == WIDTH - 1) begin : g_top
      assign w_left = i_si_msb;
    end else begin : g_inner_l
      assign w_left = w_q[i+1];
    end

    if (i == 0) begin : g_bot
      assign w_right = i_si_lsb;
    end else begin : g_inner_r
      assign w_right = w_q[i-1];
    end

    usr_cell #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_cell (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_en         (i_en),
      .i_mode       (i_mode),
      .i_d          (i_d[i]),
      .i_from_left  (w_left),
      .i_from_right (w_right),
      .o_q          (w_q[i])
    );
  end

  assign w_full = (r_cnt == CW'(WIDTH));

  // Count shifts in either direction since the last load or reset; the
  // count sticks at WIDTH so DONE stays up while data keeps moving.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_en) begin
      case (mode_t'(i_mode))
        MODE_LOAD: r_cnt <= '0;
        MODE_SHR,
        MODE_SHL: begin
          if (!w_full) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default:   r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_q      = w_q;
  assign o_so_lsb = w_q[0];
  assign o_so_msb = w_q[WIDTH-1];
  assign o_cnt    = r_cnt;
  assign o_done   = w_full;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: an 8-bit instance with zero reset value and a
// 4-bit instance with a non-zero reset value share one set of controls.
// A word-level model (integer arithmetic on the register value and a plain
// integer count) tracks both; directed sequences are followed by random ones.
module tb_univ_shift_reg;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [7:0] d;
  logic       siMsb;
  logic       siLsb;

  logic [7:0] q8;
  logic       soLsb8, soMsb8, done8;
  logic [3:0] cnt8;
  logic [3:0] q4;
  logic       soLsb4, soMsb4, done4;
  logic [2:0] cnt4;

  int checks = 0;
  int errors = 0;

  int modelQ8, modelCnt8, modelQ4, modelCnt4;

  localparam int RV4 = 10;

  // Free-running clock; stimulus moves on the falling edge.
  always #5 clock = ~clock;

  univ_shift_reg #(.WIDTH(8)) dut8 (
    .i_clk(clock), .i_reset(reset), .i_en(en), .i_mode(mode), .i_d(d),
    .i_si_msb(siMsb), .i_si_lsb(siLsb), .o_q(q8), .o_so_lsb(soLsb8),
    .o_so_msb(soMsb8), .o_cnt(cnt8), .o_done(done8)
  );

  univ_shift_reg #(.WIDTH(4), .RESET_VALUE(4'hA)) dut4 (
    .i_clk(clock), .i_reset(reset), .i_en(en), .i_mode(mode), .i_d(d[3:0]),
    .i_si_msb(siMsb), .i_si_lsb(siLsb), .o_q(q4), .o_so_lsb(soLsb4),
    .o_so_msb(soMsb4), .o_cnt(cnt4), .o_done(done4)
  );

  // Single comparison point: counts every check and every failure.
  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Word-level behaviour of one register for one rising edge.
  task automatic modelStep(input int width, input int resetVal, inout int q, inout int cnt);
    int full;
    full = 1 << width;
    if (reset) begin
      q   = resetVal;
      cnt = 0;
    end else if (en) begin
      case (mode)
        2'd1: begin q = int'(d) % full; cnt = 0; end
        2'd2: begin q = q / 2 + (siMsb ? full / 2 : 0); cnt = (cnt < width) ? cnt + 1 : width; end
        2'd3: begin q = (q * 2 + int'(siLsb)) % full; cnt = (cnt < width) ? cnt + 1 : width; end
        default: ;
      endcase
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic checkOutput();
    check("q8",      64'(q8),      64'(modelQ8));
    check("cnt8",    64'(cnt8),    64'(modelCnt8));
    check("done8",   64'(done8),   64'(modelCnt8 == 8));
    check("soLsb8",  64'(soLsb8),  64'(modelQ8 % 2));
    check("soMsb8",  64'(soMsb8),  64'(modelQ8 / 128));
    check("q4",      64'(q4),      64'(modelQ4));
    check("cnt4",    64'(cnt4),    64'(modelCnt4));
    check("done4",   64'(done4),   64'(modelCnt4 == 4));
    check("soLsb4",  64'(soLsb4),  64'(modelQ4 % 2));
    check("soMsb4",  64'(soMsb4),  64'(modelQ4 / 8));
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the
  // rising edge, then check just after it.
  task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                               input logic [7:0] dd, input logic sm, input logic sl);
    @(negedge clock);
    reset = r; en = e; mode = m; d = dd; siMsb = sm; siLsb = sl;
    @(posedge clock);
    modelStep(8, 0, modelQ8, modelCnt8);
    modelStep(4, RV4, modelQ4, modelCnt4);
    #1;
    checkOutput();
  endtask

  // Directed scenarios first, then random traffic against the model.
  initial begin
    logic [7:0] pisoWord;
    logic [7:0] sipoBits;
    reset = 1'b1; en = 1'b1; mode = 2'd1; d = 8'hA5; siMsb = 1'b0; siLsb = 1'b0;
    modelQ8 = 0; modelCnt8 = 0; modelQ4 = RV4; modelCnt4 = 0;

    $display("[TB] reset");
    applyStimulus(1, 1, 2'd1, 8'hA5, 0, 0);
    applyStimulus(1, 1, 2'd1, 8'hA5, 0, 0);
    check("rst_q8", 64'(q8), 64'h00);
    check("rst_cnt8", 64'(cnt8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_q4", 64'(q4), 64'hA);

    $display("[TB] load and enable gating");
    applyStimulus(0, 1, 2'd1, 8'hA5, 0, 0);
    check("load_q8", 64'(q8), 64'hA5);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 2'd1, 8'h3C, 1, 1);
    check("gate_q8", 64'(q8), 64'hA5);

    $display("[TB] PISO");
    pisoWord = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      check("piso_bit", 64'(soLsb8), 64'(pisoWord[i]));
      applyStimulus(0, 1, 2'd2, 8'h00, 0, 0);
    end
    check("piso_q8", 64'(q8), 64'h00);
    check("piso_cnt8", 64'(cnt8), 64'd8);
    check("piso_done8", 64'(done8), 64'd1);
    applyStimulus(0, 1, 2'd2, 8'h00, 0, 0);
    check("sat_cnt8", 64'(cnt8), 64'd8);
    check("sat_done8", 64'(done8), 64'd1);

    $display("[TB] SIPO");
    applyStimulus(0, 1, 2'd1, 8'h00, 0, 0);
    sipoBits = 8'hCA;
    for (int i = 7; i >= 0; i--) applyStimulus(0, 1, 2'd3, 8'h00, 0, sipoBits[i]);
    check("sipo_q8", 64'(q8), 64'hCA);
    check("sipo_done8", 64'(done8), 64'd1);
    check("sipo_soMsb8", 64'(soMsb8), 64'd1);

    $display("[TB] restart after done");
    applyStimulus(0, 1, 2'd1, 8'h81, 0, 0);
    check("restart_q8", 64'(q8), 64'h81);
    check("restart_cnt8", 64'(cnt8), 64'd0);
    check("restart_done8", 64'(done8), 64'd0);
    applyStimulus(0, 1, 2'd0, 8'hFF, 1, 1);
    applyStimulus(0, 1, 2'd0, 8'hFF, 1, 1);
    check("hold_q8", 64'(q8), 64'h81);

    $display("[TB] reset mid-operation");
    applyStimulus(0, 1, 2'd1, 8'hFF, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 2'd2, 8'h00, 0, 0);
    check("mid_q8", 64'(q8), 64'h1F);
    check("mid_cnt8", 64'(cnt8), 64'd3);
    applyStimulus(1, 1, 2'd2, 8'h00, 1, 1);
    check("midrst_q8", 64'(q8), 64'h00);
    check("midrst_cnt8", 64'(cnt8), 64'd0);
    check("midrst_done8", 64'(done8), 64'd0);

    $display("[TB] width 4");
    applyStimulus(0, 1, 2'd1, 8'h09, 0, 0);
    check("w4_load", 64'(q4), 64'h9);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 2'd2, 8'h00, 1, 0);
    check("w4_q", 64'(q4), 64'hF);
    check("w4_done", 64'(done4), 64'd1);

    $display("[TB] random");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)), 8'($urandom),
                    1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register. Successor to the single-bit enabled D flip-flop and the fixed PIPO register.
- One WIDTH-bit register supports four modes: hold, parallel load (PIPO/PISO), shift right and shift left (SISO/SIPO).
- Has serial inputs and outputs at both ends.
- A shift counter and DONE flag mark when a full word has been serialised in or out.
- Used as the general serialiser/deserialiser building block in later datapath tasks.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VALUE, '0, value loaded into Q on reset (WIDTH bits).
- localparam CW = $clog2(WIDTH+1), width of CNT.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- EN  in  1  clock enable; when low, all state holds.
- MODE  in  2  operation select (mode_t): 00 HOLD, 01 LOAD, 10 SHR, 11 SHL.
- D  in  WIDTH  parallel load data.
- SI_MSB  in  1  serial input entering bit WIDTH-1 on SHR.
- SI_LSB  in  1  serial input entering bit 0 on SHL.
- Q  out  WIDTH  register contents (parallel out).
- SO_LSB  out  1  Q[0], serial out for SHR.
- SO_MSB  out  1  Q[WIDTH-1], serial out for SHL.
- CNT  out  CW  number of shifts since the last LOAD or reset, saturating at WIDTH.
- DONE  out  1  high when CNT == WIDTH.

Behaviour:
- All registers are sampled on posedge CLK only. There is no asynchronous path.
- Reset has priority over EN and MODE. On an edge with Reset=1: Q <= RESET_VALUE, CNT <= 0. So DONE=0, SO_LSB=RESET_VALUE[0], SO_MSB=RESET_VALUE[WIDTH-1].
- Reset asserted mid-shift discards the partial word. The counter restarts at 0 on the same edge.
- EN=0 (Reset=0): Q and CNT hold, regardless of MODE, D or serial inputs.
- EN=1, MODE=HOLD: Q and CNT hold.
- EN=1, MODE=LOAD: Q <= D, CNT <= 0. Latency is 1 edge. LOAD while DONE=1 restarts the count.
- EN=1, MODE=SHR: Q <= {SI_MSB, Q[WIDTH-1:1]}; CNT <= (CNT==WIDTH) ? WIDTH : CNT+1.
- EN=1, MODE=SHL: Q <= {Q[WIDTH-2:0], SI_LSB}; CNT increments with the same saturation rule as SHR.
- Mixing SHR and SHL without an intervening LOAD is legal. The counter counts both directions.
- SO_LSB, SO_MSB and DONE are combinational from the registered Q and CNT. There is no input-to-output combinational path.
- Shifting past WIDTH continues to move data. CNT stays at WIDTH and DONE stays high; CNT never wraps.
- Timing convention: stimulus changes on the falling edge and is checked after the following rising edge. Q is valid 1 edge after a LOAD or SHIFT command.

Decomposition:
- Package usr_pkg:
  - typedef enum logic [1:0] mode_t {MODE_HOLD=2'b00, MODE_LOAD=2'b01, MODE_SHR=2'b10, MODE_SHL=2'b11}.
  - Helper function cnt_width(int w) returning $clog2(w+1).
- One natural sub-module: usr_cell. It is a 1-bit slice containing a 4:1 mode mux (hold/D/left-neighbour/right-neighbour) plus a flip-flop with synchronous active-high reset and an enable.
- WIDTH cells are instantiated by generate. Boundary neighbours connect to SI_MSB/SI_LSB.
- The counter/DONE logic lives in the top module.

Test Plan:
- Reset: Reset=1 for 2 edges with EN=1, MODE=LOAD, D=8'hA5 -> Q=8'h00, CNT=0, DONE=0.
- Load and enable gating: LOAD D=8'hA5 -> Q=8'hA5, CNT=0. Then EN=0, MODE=LOAD, D=8'h3C for 3 edges -> Q stays 8'hA5.
- PISO: LOAD 8'hA5, then SHR ×8 with SI_MSB=0 -> SO_LSB before each edge reads 1,0,1,0,0,1,0,1. Final Q=8'h00, CNT=8, DONE=1. A 9th SHR leaves CNT=8, DONE=1.
- SIPO: after LOAD 8'h00, SHL ×8 with SI_LSB = 1,1,0,0,1,0,1,0 -> Q=8'hCA, CNT=8, DONE=1. SO_MSB=1 after the last edge.
- Reset mid-operation: LOAD 8'hFF, SHR ×3 with SI_MSB=0 -> Q=8'h1F, CNT=3. Then Reset=1 with EN=1, MODE=SHR -> Q=8'h00, CNT=0, DONE=0 after one edge.
- Restart after DONE: from DONE=1, LOAD 8'h81 -> Q=8'h81, CNT=0, DONE=0. HOLD ×2 -> unchanged. WIDTH=4 instance: LOAD 4'h9, SHR ×4 with SI_MSB=1 -> Q=4'hF, DONE=1.
